// File: rtl/axis_pixels_halo.sv
// axis_pixels_halo: turns packed image-column beats into per-tap row vectors, rebuilding the top halo from a RAM.
// Optional feature macro: PIXELS_TAP_USER_EN (drive m_tap with the tap index; otherwise m_tap is 0).
module axis_pixels_halo #(
  parameter int ROWS       = 8,
  parameter int KH_MAX     = 7,
  parameter int CI_MAX     = 512,
  parameter int XW_MAX     = 256,
  parameter int XH_MAX     = 256,
  parameter int WORD_WIDTH = 8,
  parameter int EDGE       = KH_MAX / 2,
  parameter int RAM_DEPTH  = CI_MAX * XW_MAX
) (
  input  logic                               aclk,
  input  logic                               aresetn,
  input  logic                               s_valid,
  output logic                               s_ready,
  input  logic                               s_last,
  input  logic [(ROWS+EDGE)*WORD_WIDTH-1:0]  s_data,
  input  logic [$clog2(EDGE+1)+$clog2(CI_MAX)+$clog2(XW_MAX)+$clog2(XH_MAX/ROWS)-1:0] s_user,
  input  logic                               m_ready,
  output logic                               m_valid,
  output logic                               m_last,
  output logic [ROWS*WORD_WIDTH-1:0]         m_data,
  output logic [$clog2(KH_MAX)-1:0]          m_tap,
  output logic                               err
);

  localparam int KW = $clog2(EDGE + 1);
  localparam int CW = $clog2(CI_MAX);
  localparam int WW = $clog2(XW_MAX);
  localparam int BW = $clog2(XH_MAX / ROWS);
  localparam int TW = $clog2(KH_MAX);
  localparam int AW = $clog2(RAM_DEPTH);
  localparam int HW = EDGE * WORD_WIDTH;
  localparam int VW = (ROWS + 2 * EDGE) * WORD_WIDTH;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  state_t state_q, state_d;

  logic [KW-1:0] kh2_q;
  logic [CW-1:0] ci_max_q, ci_q;
  logic [WW-1:0] w_max_q, w_q;
  logic [BW-1:0] blk_max_q, blk_q;
  logic [AW-1:0] addr_q;

  logic                       h_valid_q, h_top_zero_q, h_wr_q, h_final_q;
  logic [TW-1:0]              h_t_q;
  logic [ROWS*WORD_WIDTH-1:0] h_rows_q;
  logic [HW-1:0]              h_bot_q;
  logic [AW-1:0]              h_addr_q;

  logic [HW-1:0] mem_q [RAM_DEPTH];
  logic [HW-1:0] ram_q;

  logic                       m_valid_q, m_last_q, err_q;
  logic [ROWS*WORD_WIDTH-1:0] m_data_q;

  logic [KW-1:0]              kh2_in;
  logic [TW-1:0]              tmax;
  logic                       cfg_load, accept, final_beat, last_blk;
  logic                       o_load, h_adv, h_done, h_wr_fire;
  logic [HW-1:0]              top_v, wr_v;
  logic [VW-1:0]              win_v;
  logic [ROWS*WORD_WIDTH-1:0] tap_data;

  assign kh2_in     = s_user[KW-1:0];
  assign tmax       = TW'({kh2_q, 1'b0});
  assign cfg_load   = (state_q == S_IDLE) && s_valid;
  assign final_beat = (ci_q == ci_max_q) && (w_q == w_max_q) && (blk_q == blk_max_q);
  assign last_blk   = (blk_q == blk_max_q);

  assign o_load    = !m_valid_q || m_ready;
  assign h_adv     = h_valid_q && o_load;
  assign h_done    = h_adv && (h_t_q == tmax);
  assign h_wr_fire = h_adv && (h_t_q == '0) && h_wr_q;
  assign s_ready   = (state_q == S_RUN) && (!h_valid_q || h_done);
  assign accept    = s_valid && s_ready;

  always_ff @(posedge aclk) begin
    if (!aresetn) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (s_valid) state_d = S_RUN;
      S_RUN:   if (accept && final_beat) state_d = S_DRAIN;
      S_DRAIN: if (m_valid_q && m_ready && m_last_q) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Header fields; an unsupported kernel half-height falls back to KH = 1.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      kh2_q     <= '0;
      ci_max_q  <= '0;
      w_max_q   <= '0;
      blk_max_q <= '0;
    end else if (cfg_load) begin
      kh2_q     <= (int'(kh2_in) > EDGE) ? '0 : kh2_in;
      ci_max_q  <= s_user[KW +: CW];
      w_max_q   <= s_user[KW+CW +: WW];
      blk_max_q <= s_user[KW+CW+WW +: BW];
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn || cfg_load) begin
      ci_q   <= '0;
      w_q    <= '0;
      blk_q  <= '0;
      addr_q <= '0;
    end else if (accept) begin
      if (ci_q == ci_max_q) begin
        ci_q <= '0;
        if (w_q == w_max_q) begin
          w_q    <= '0;
          blk_q  <= blk_q + 1'b1;
          addr_q <= '0;
        end else begin
          w_q    <= w_q + 1'b1;
          addr_q <= addr_q + 1'b1;
        end
      end else begin
        ci_q   <= ci_q + 1'b1;
        addr_q <= addr_q + 1'b1;
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) err_q <= 1'b0;
    else if (accept && (s_last != final_beat)) err_q <= 1'b1;
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      h_valid_q    <= 1'b0;
      h_t_q        <= '0;
      h_rows_q     <= '0;
      h_bot_q      <= '0;
      h_top_zero_q <= 1'b1;
      h_wr_q       <= 1'b0;
      h_final_q    <= 1'b0;
      h_addr_q     <= '0;
    end else if (accept) begin
      h_valid_q    <= 1'b1;
      h_t_q        <= '0;
      h_rows_q     <= s_data[ROWS*WORD_WIDTH-1:0];
      h_bot_q      <= last_blk ? '0 : s_data[(ROWS+EDGE)*WORD_WIDTH-1:ROWS*WORD_WIDTH];
      h_top_zero_q <= (blk_q == '0);
      h_wr_q       <= !last_blk && (kh2_q != '0);
      h_final_q    <= final_beat;
      h_addr_q     <= addr_q;
    end else if (h_done) begin
      h_valid_q <= 1'b0;
    end else if (h_adv) begin
      h_t_q <= h_t_q + 1'b1;
    end
  end

  always_ff @(posedge aclk) begin
    if (h_wr_fire) mem_q[h_addr_q] <= wr_v;
    if (accept)    ram_q <= mem_q[addr_q];
  end

  // Window and halo slices are built per possible kh2 so every select stays constant.
  always_comb begin
    top_v = h_top_zero_q ? '0 : ram_q;
    win_v = '0;
    wr_v  = '0;
    for (int unsigned k = 0; k <= EDGE; k++) begin
      if (32'(kh2_q) == k) begin
        for (int unsigned j = 0; j < k; j++) begin
          win_v[j*WORD_WIDTH +: WORD_WIDTH]          = top_v[j*WORD_WIDTH +: WORD_WIDTH];
          win_v[(k+ROWS+j)*WORD_WIDTH +: WORD_WIDTH] = h_bot_q[j*WORD_WIDTH +: WORD_WIDTH];
          wr_v[j*WORD_WIDTH +: WORD_WIDTH]           = h_rows_q[(ROWS-k+j)*WORD_WIDTH +: WORD_WIDTH];
        end
        win_v[k*WORD_WIDTH +: ROWS*WORD_WIDTH] = h_rows_q;
      end
    end
    tap_data = win_v[32'(h_t_q)*WORD_WIDTH +: ROWS*WORD_WIDTH];
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      m_valid_q <= 1'b0;
      m_last_q  <= 1'b0;
      m_data_q  <= '0;
    end else if (o_load) begin
      m_valid_q <= h_valid_q;
      m_last_q  <= h_valid_q && h_final_q && (h_t_q == tmax);
      if (h_valid_q) m_data_q <= tap_data;
    end
  end

`ifdef PIXELS_TAP_USER_EN
  logic [TW-1:0] m_tap_q;

  always_ff @(posedge aclk) begin
    if (!aresetn)                   m_tap_q <= '0;
    else if (o_load && h_valid_q)   m_tap_q <= h_t_q;
  end

  assign m_tap = m_tap_q;
`else
  assign m_tap = '0;
`endif

  assign m_valid = m_valid_q;
  assign m_last  = m_last_q;
  assign m_data  = m_data_q;
  assign err     = err_q;

endmodule

// File: tb/tb_axis_pixels_halo.sv
// tb_axis_pixels_halo: randomized frames checked against a zero-padded column convolution-window model.
module tb_axis_pixels_halo;

  localparam int ROWS = 8;
  localparam int KH_MAX = 7;
  localparam int EDGE = KH_MAX / 2;
  localparam int W = 8;
  localparam int UW = 2 + 9 + 8 + 5;

  typedef struct {
    logic [63:0] data;
    int          tap;
    logic        last;
  } exp_t;

  logic                       aclk = 1'b0;
  logic                       aresetn = 1'b0;
  logic                       s_valid = 1'b0;
  logic                       s_ready;
  logic                       s_last = 1'b0;
  logic [(ROWS+EDGE)*W-1:0]   s_data = '0;
  logic [UW-1:0]              s_user = '0;
  logic                       m_ready = 1'b1;
  logic                       m_valid, m_last, err;
  logic [ROWS*W-1:0]          m_data;
  logic [2:0]                 m_tap;

  axis_pixels_halo #(
    .ROWS(8), .KH_MAX(7), .CI_MAX(512), .XW_MAX(256), .XH_MAX(256), .WORD_WIDTH(8)
  ) dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_valid(s_valid), .s_ready(s_ready), .s_last(s_last), .s_data(s_data), .s_user(s_user),
    .m_ready(m_ready), .m_valid(m_valid), .m_last(m_last), .m_data(m_data), .m_tap(m_tap),
    .err(err)
  );

  always #5 aclk = ~aclk;

  int   cyc = 0;
  always @(posedge aclk) cyc <= cyc + 1;

  int   n_chk = 0;
  int   n_bad = 0;
  exp_t expq[$];
  logic [7:0] img [32][4][4];
  bit   rdy_rand = 1'b0;
  int   first_acc = -1;
  int   first_mv = -1;
  bit   err_exp = 1'b0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_chk++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s got=%h want=%h (t=%0t)", tag, got, want, $time);
    end
  endtask

  initial forever begin
    @(posedge aclk);
    #1;
    m_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  initial begin : monitor
    bit          stall;
    logic [63:0] hold_d;
    logic [2:0]  hold_t;
    logic        hold_l;
    exp_t        e;
    stall = 1'b0;
    forever begin
      @(negedge aclk);
      if (!aresetn) begin
        stall = 1'b0;
      end else begin
        if (stall) begin
          check_eq("hold_valid", m_valid, 1);
          check_eq("hold_data", m_data, hold_d);
          check_eq("hold_tap", m_tap, hold_t);
          check_eq("hold_last", m_last, hold_l);
        end
        if (s_valid && s_ready && first_acc < 0) first_acc = cyc;
        if (m_valid && first_mv < 0) first_mv = cyc;
        if (m_valid && m_ready) begin
          if (expq.size() == 0) begin
            check_eq("extra_out", m_valid, 0);
          end else begin
            e = expq.pop_front();
            check_eq("data", m_data, e.data);
`ifdef PIXELS_TAP_USER_EN
            check_eq("tap", m_tap, e.tap);
`else
            check_eq("tap", m_tap, 0);
`endif
            check_eq("last", m_last, e.last);
          end
        end
        stall  = m_valid && !m_ready;
        hold_d = m_data;
        hold_t = m_tap;
        hold_l = m_last;
      end
    end
  end

  task automatic do_reset();
    @(posedge aclk);
    #1;
    aresetn = 1'b0;
    s_valid = 1'b0;
    s_last  = 1'b0;
    @(posedge aclk);
    #1;
    check_eq("rst_m_valid", m_valid, 0);
    check_eq("rst_m_last", m_last, 0);
    check_eq("rst_m_data", m_data, 0);
    check_eq("rst_m_tap", m_tap, 0);
    check_eq("rst_err", err, 0);
    check_eq("rst_s_ready", s_ready, 0);
    expq.delete();
    err_exp = 1'b0;
    @(posedge aclk);
    #1;
    aresetn = 1'b1;
  endtask

  // Expected output: tap t, row r of the beat at block blk is image row blk*ROWS+r+t-kh2 (0 outside image).
  task automatic run_frame(input int kh2, input int ci_n, input int w_n, input int nb,
                           input bit incr, input bit new_img, input int bad_beat, input int abort_beat);
    int   kh;
    int   hgt;
    int   nbeats;
    int   b;
    int   k;
    int   row;
    bit   got;
    bit   chk_err;
    exp_t e;
    kh = 2 * kh2 + 1;
    hgt = nb * ROWS;
    nbeats = ci_n * w_n * nb;
    k = 0;
    chk_err = 1'b0;
    if (new_img)
      for (int r = 0; r < 32; r++)
        for (int x = 0; x < 4; x++)
          for (int c = 0; c < 4; c++) begin
            img[r][x][c] = incr ? 8'(k) : 8'($urandom);
            k++;
          end
    b = 0;
    for (int blk = 0; blk < nb; blk++)
      for (int x = 0; x < w_n; x++)
        for (int c = 0; c < ci_n; c++) begin
          for (int t = 0; t < kh; t++) begin
            e.data = '0;
            for (int r = 0; r < ROWS; r++) begin
              row = blk * ROWS + r + t - kh2;
              if (row >= 0 && row < hgt) e.data[r*W +: W] = img[row][x][c];
            end
            e.tap  = t;
            e.last = (b == nbeats - 1) && (t == kh - 1);
            expq.push_back(e);
          end
          b++;
        end
    first_acc = -1;
    first_mv  = -1;
    s_user = {5'(nb - 1), 8'(w_n - 1), 9'(ci_n - 1), 2'(kh2)};
    b = 0;
    for (int blk = 0; blk < nb; blk++)
      for (int x = 0; x < w_n; x++)
        for (int c = 0; c < ci_n; c++) begin
          for (int r = 0; r < ROWS; r++) s_data[r*W +: W] = img[blk*ROWS + r][x][c];
          for (int j = 0; j < EDGE; j++)
            s_data[(ROWS+j)*W +: W] = (blk < nb - 1) ? img[(blk+1)*ROWS + j][x][c] : 8'($urandom);
          s_last  = (bad_beat >= 0) ? (b == bad_beat) : (b == nbeats - 1);
          s_valid = 1'b1;
          got = 1'b0;
          for (int n = 0; n < 2000 && !got; n++) begin
            @(negedge aclk);
            if (chk_err) begin
              check_eq("err_next", err, 1);
              chk_err = 1'b0;
            end
            if (s_ready) got = 1'b1;
          end
          if (!got) begin
            check_eq("accept_timeout", s_ready, 1);
            s_valid = 1'b0;
            return;
          end
          check_eq("err_pre", err, err_exp);
          if (b == bad_beat) begin
            err_exp = 1'b1;
            chk_err = 1'b1;
          end
          @(posedge aclk);
          #1;
          if (b == abort_beat) begin
            do_reset();
            return;
          end
          b++;
        end
    s_valid = 1'b0;
    s_last  = 1'b0;
    for (int n = 0; n < 5000 && expq.size() > 0; n++) @(negedge aclk);
    check_eq("drain_left", expq.size(), 0);
    @(negedge aclk);
    @(negedge aclk);
    check_eq("end_m_valid", m_valid, 0);
    check_eq("end_s_ready", s_ready, 0);
    check_eq("end_err", err, err_exp);
    check_eq("latency", 64'(first_mv - first_acc), 2);
  endtask

  initial begin
    do_reset();
    rdy_rand = 1'b0;
    run_frame(1, 2, 2, 2, 1'b1, 1'b1, -1, -1);
    run_frame(0, 2, 1, 2, 1'b0, 1'b1, -1, -1);
    run_frame(3, 2, 3, 3, 1'b0, 1'b1, -1, -1);
    rdy_rand = 1'b1;
    run_frame(3, 2, 3, 3, 1'b0, 1'b0, -1, -1);
    rdy_rand = 1'b0;
    run_frame(1, 1, 2, 2, 1'b0, 1'b1, 2, -1);
    do_reset();
    rdy_rand = 1'b1;
    run_frame(1, 2, 2, 3, 1'b0, 1'b1, -1, 5);
    run_frame(1, 2, 2, 2, 1'b0, 1'b1, -1, -1);
    run_frame(2, 3, 2, 2, 1'b0, 1'b1, -1, -1);
    run_frame(3, 1, 1, 3, 1'b0, 1'b1, -1, -1);
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
